// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - instruction FIFO with MIPS field decode of the head entry
// Captures fetched words and PCs; flush empties the queue in one cycle.
module instruction_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  memory_output,
  input  logic [ADDR_WIDTH-1:0]        in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [31:0]                  instr,
  output logic [5:0]                   control_input,
  output logic [4:0]                   source_1,
  output logic [4:0]                   source_2,
  output logic [4:0]                   dest,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  immediate,
  output logic [31:0]                  imm_sext,
  output logic [31:0]                  imm_zext,
  output logic [25:0]                  jmp_address,
  output logic [ADDR_WIDTH-1:0]        jmp_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]           instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;
  logic                  nonempty;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [3:0]            pc_top;

  // Everything visible is gated by reset_n so the queue looks empty during reset.
  assign nonempty  = reset_n && (count_q != '0);
  assign out_valid = nonempty;
  assign in_ready  = reset_n && ((count_q < FULL) || out_ready);
  assign count     = reset_n ? count_q : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign instr  = nonempty ? instr_mem[rd_ptr] : '0;
  assign out_pc = nonempty ? pc_mem[rd_ptr]    : '0;

  assign control_input = instr[31:26];
  assign source_1      = instr[25:21];
  assign source_2      = instr[20:16];
  assign dest          = instr[15:11];
  assign shamt         = instr[10:6];
  assign funct         = instr[5:0];
  assign immediate     = instr[15:0];
  assign imm_sext      = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext      = {16'h0000, instr[15:0]};
  assign jmp_address   = instr[25:0];

  assign pc_plus4   = out_pc + ADDR_WIDTH'(4);
  assign pc_top     = 4'(32'(pc_plus4) >> 28);
  assign jmp_target = ADDR_WIDTH'({pc_top, jmp_address, 2'b00});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (flush) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately not reset; the empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= memory_output;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - table-driven self-checking bench for instruction_queue
module tb_instruction_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   memory_output, instr, imm_sext, imm_zext;
  logic [AW-1:0] in_pc, out_pc, jmp_target;
  logic [5:0]    control_input, funct;
  logic [4:0]    source_1, source_2, dest, shamt;
  logic [15:0]   immediate;
  logic [25:0]   jmp_address;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .memory_output(memory_output), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .instr(instr),
    .control_input(control_input), .source_1(source_1), .source_2(source_2),
    .dest(dest), .shamt(shamt), .funct(funct), .immediate(immediate),
    .imm_sext(imm_sext), .imm_zext(imm_zext), .jmp_address(jmp_address),
    .jmp_target(jmp_target), .count(count)
  );

  typedef struct {
    logic        rn, iv;
    logic [31:0] word, pc;
    logic        ordy, fl;
    logic        ev;
    logic [2:0]  ecnt;
    logic        er;
    logic [31:0] einstr, epc;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_fields(input logic [31:0] w, input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (w == 32'h0) p4 = 32'h0;
    chk("control_input", 32'(control_input), 32'(w[31:26]));
    chk("source_1",      32'(source_1),      32'(w[25:21]));
    chk("source_2",      32'(source_2),      32'(w[20:16]));
    chk("dest",          32'(dest),          32'(w[15:11]));
    chk("shamt",         32'(shamt),         32'(w[10:6]));
    chk("funct",         32'(funct),         32'(w[5:0]));
    chk("immediate",     32'(immediate),     32'(w[15:0]));
    chk("imm_sext",      imm_sext,           {{16{w[15]}}, w[15:0]});
    chk("imm_zext",      imm_zext,           {16'h0, w[15:0]});
    chk("jmp_address",   32'(jmp_address),   32'(w[25:0]));
    chk("jmp_target",    jmp_target,         {p4[31:28], w[25:0], 2'b00});
  endtask

  task automatic drive(input logic rn, input logic iv, input logic [31:0] w,
                       input logic [31:0] pc, input logic ordy, input logic fl);
    @(negedge clk);
    reset_n = rn; in_valid = iv; memory_output = w; in_pc = pc;
    out_ready = ordy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; memory_output = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;

    //          rn    iv    word          pc            ordy  fl    ev    cnt   er    instr         pc
    vt[0] = '{1'b0, 1'b1, 32'h8C430004, 32'h00000100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0};
    vt[1] = '{1'b0, 1'b1, 32'h8C430004, 32'h00000100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        32'h0};
    vt[2] = '{1'b1, 1'b1, 32'h8C430004, 32'h00000100, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h8C430004, 32'h00000100};
    vt[3] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0,        32'h0};
    vt[4] = '{1'b1, 1'b1, 32'h2008FFFF, 32'h00000104, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h2008FFFF, 32'h00000104};
    vt[5] = '{1'b1, 1'b1, 32'h08000040, 32'h00000400, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 32'h08000040, 32'h00000400};
    vt[6] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0,        32'h0};
    vt[7] = '{1'b1, 1'b1, 32'h0BFFFFFF, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h0BFFFFFF, 32'hFFFFFFFC};
    vt[8] = '{1'b1, 1'b1, 32'h08000001, 32'hF0000000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 32'h08000001, 32'hF0000000};
    vt[9] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 32'h0,        32'h0};

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].rn, vt[i].iv, vt[i].word, vt[i].pc, vt[i].ordy, vt[i].fl);
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d count", i),     32'(count),     32'(vt[i].ecnt));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vt[i].er));
      chk($sformatf("v%0d instr", i),     instr,          vt[i].einstr);
      chk($sformatf("v%0d out_pc", i),    out_pc,         vt[i].epc);
      check_fields(vt[i].einstr, vt[i].epc);
    end

    // decoded values written out by hand for the lw, addi and j examples
    drive(1'b1, 1'b1, 32'h8C430004, 32'h100, 1'b0, 1'b0);
    tick();
    chk("lw control_input", 32'(control_input), 32'h23);
    chk("lw source_1", 32'(source_1), 32'd2);
    chk("lw source_2", 32'(source_2), 32'd3);
    chk("lw immediate", 32'(immediate), 32'h4);
    chk("lw imm_sext", imm_sext, 32'h00000004);
    chk("lw out_pc", out_pc, 32'h100);
    drive(1'b1, 1'b1, 32'h2008FFFF, 32'h104, 1'b1, 1'b0);
    tick();
    chk("addi imm_sext", imm_sext, 32'hFFFFFFFF);
    chk("addi imm_zext", imm_zext, 32'h0000FFFF);
    drive(1'b1, 1'b1, 32'h08000040, 32'h400, 1'b1, 1'b0);
    tick();
    chk("j jmp_address", 32'(jmp_address), 32'h40);
    chk("j jmp_target", jmp_target, 32'h100);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain count", 32'(count), 32'd0);

    // fill to DEPTH, then stream 10 words through a full queue across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h10000000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    chk("full count", 32'(count), 32'd4);
    chk("full in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEAD, 1'b0, 1'b0);
    tick();
    chk("full ignore count", 32'(count), 32'd4);
    chk("full ignore head", instr, 32'h10000000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'h10000000 + 32'(i + DEPTH), 32'((i + DEPTH) * 4), 1'b1, 1'b0);
      #1;
      chk($sformatf("wrap%0d head", i), instr, 32'h10000000 + 32'(i));
      chk($sformatf("wrap%0d pc", i), out_pc, 32'(i * 4));
      chk($sformatf("wrap%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("wrap%0d count", i), 32'(count), 32'd4);
    end
    for (int i = 10; i < 14; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      chk($sformatf("tail%0d head", i), instr, 32'h10000000 + 32'(i));
      tick();
    end
    chk("tail empty", 32'(out_valid), 32'd0);

    // flush at count 3 with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h20000000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    chk("pre-flush count", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 32'hAAAA5555, 32'h300, 1'b1, 1'b1);
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("flush count", 32'(count), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush instr", instr, 32'h0);
    drive(1'b1, 1'b1, 32'h3C010123, 32'h340, 1'b0, 1'b0);
    tick();
    chk("post-flush head", instr, 32'h3C010123);
    chk("post-flush pc", out_pc, 32'h340);
    chk("post-flush count", 32'(count), 32'd1);

    // reset mid-operation overrides flush and handshakes
    drive(1'b0, 1'b1, 32'h11111111, 32'h500, 1'b1, 1'b1);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst instr", instr, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("after rst count", 32'(count), 32'd0);
    chk("after rst out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
